sec_countdown_timer: RTL
========================

// Module: sec_countdown_timer
// PURPOSE
//   BCD mm:ss countdown timer clocked by the divider's once-per-second tick clk_tmp1.
//   It is the consumer end of the clock-divider interface: the divider produces the
//   slow edge and this block spends it, decrementing one second per edge.
//   Outputs are BCD digits for the 7-seg scan logic plus done/running status.
// PARAMETERS
//   MIN_TENS_MAX  5   largest legal minutes-tens digit (max preset 59:59)
// PORTS
//   clk_tmp1    in   1  timer clock, one rising edge per second
//   rst_n       in   1  reset, asynchronous, active-low
//   run         in   1  level: 1 = count down, 0 = pause; sampled on clk_tmp1 edges
//   load        in   1  level: copy preset into counter; priority over run
//   pre_min_t   in   4  preset minutes tens (BCD)
//   pre_min_o   in   4  preset minutes ones (BCD)
//   pre_sec_t   in   4  preset seconds tens (BCD)
//   pre_sec_o   in   4  preset seconds ones (BCD)
//   min_t       out  4  current minutes tens
//   min_o       out  4  current minutes ones
//   sec_t       out  4  current seconds tens
//   sec_o       out  4  current seconds ones
//   state       out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//   running     out  1  1 while state==RUN
//   done        out  1  1 while state==DONE
//   sec_pulse   out  1  1 for the single edge-period following a decrement
// BEHAVIOUR
//   - All outputs registered on posedge clk_tmp1. Reset: digits 0, state IDLE,
//     running 0, done 0, sec_pulse 0. Reset mid-count aborts immediately.
//   - load=1 (any state): digits <= clamped preset, state IDLE, done 0, sec_pulse 0.
//     Clamp: ones/sec_o digit >9 -> 9; sec_t >5 -> 5; min_t >MIN_TENS_MAX -> MIN_TENS_MAX.
//   - IDLE: run=1 & count!=00:00 -> RUN (no decrement this edge);
//           run=1 & count==00:00 -> DONE; run=0 -> stay.
//   - RUN:  run=0 -> PAUSE, digits hold. run=1 -> decrement one second, sec_pulse=1;
//           if pre-decrement value is 00:01 -> value 00:00 and state DONE same edge.
//   - PAUSE: run=1 -> RUN (no decrement this edge, 1-edge resume latency); run=0 -> stay.
//   - DONE: digits hold 00:00, done=1; run ignored; exit only via load or rst_n.
//   - Decrement borrow chain: sec_o 0->9 borrows sec_t; sec_t 0->5 borrows min_o;
//     min_o 0->9 borrows min_t; min_t decrements. E.g. 10:00 -> 09:59, 01:00 -> 00:59.
//   - Counter never wraps below 00:00; all digits stay legal BCD at all times.
//   - Simultaneous load & run: load wins, run ignored that edge.
//   - Inputs are levels from the fast domain, held >=2 clk_tmp1 periods by the source;
//     no synchronizer inside (single sample per edge).
// TESTING
//   1 reset asserted mid-RUN at 00:37 -> all digits 0, state 0, done 0 immediately.
//   2 load preset 01:02, run=1 -> edge1 state RUN 01:02; edges 2..4 -> 01:01, 01:00, 00:59.
//   3 load 00:02, run=1 -> RUN, 00:01, then 00:00 with done=1,state 3; further edges hold.
//   4 running at 00:45, run=0 two edges -> PAUSE, 00:45 held; run=1 -> RUN 00:45, next 00:44.
//   5 load preset digits 7,12,8,15 -> counter 59:59 (clamped); run reaches 59:58 after 2 edges.
//   6 load=1 & run=1 together while DONE -> state IDLE, preset loaded, done=0, sec_pulse=0.

Source files
------------

// File: rtl/sec_countdown_timer.sv
// BCD mm:ss countdown timer, one second per rising edge of clk_tmp1.
// Provides preset load with clamping, run/pause control and done/running status.
module sec_countdown_timer #(
    parameter logic [3:0] MIN_TENS_MAX = 4'd5
) (
    input  logic       clk_tmp1,
    input  logic       rst_n,
    input  logic       run,
    input  logic       load,
    input  logic [3:0] pre_min_t,
    input  logic [3:0] pre_min_o,
    input  logic [3:0] pre_sec_t,
    input  logic [3:0] pre_sec_o,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic [1:0] state,
    output logic       running,
    output logic       done,
    output logic       sec_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] min_t_q, min_t_d;
    logic [3:0] min_o_q, min_o_d;
    logic [3:0] sec_t_q, sec_t_d;
    logic [3:0] sec_o_q, sec_o_d;
    logic       running_q, done_q, sec_pulse_q, sec_pulse_d;

    logic       isZero;
    logic       isOne;

    assign isZero = (min_t_q == 4'd0) && (min_o_q == 4'd0) &&
                    (sec_t_q == 4'd0) && (sec_o_q == 4'd0);
    assign isOne  = (min_t_q == 4'd0) && (min_o_q == 4'd0) &&
                    (sec_t_q == 4'd0) && (sec_o_q == 4'd1);

    // Presets are clamped digit by digit so the counter can never hold illegal BCD.
    function automatic logic [3:0] clampDigit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    always_comb begin
        state_d     = state_q;
        min_t_d     = min_t_q;
        min_o_d     = min_o_q;
        sec_t_d     = sec_t_q;
        sec_o_d     = sec_o_q;
        sec_pulse_d = 1'b0;

        if (load) begin
            min_t_d = clampDigit(pre_min_t, MIN_TENS_MAX);
            min_o_d = clampDigit(pre_min_o, 4'd9);
            sec_t_d = clampDigit(pre_sec_t, 4'd5);
            sec_o_d = clampDigit(pre_sec_o, 4'd9);
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = isZero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_d = PAUSE;
                    end else if (isZero) begin
                        state_d = DONE;
                    end else begin
                        sec_pulse_d = 1'b1;
                        if (isOne) begin
                            state_d = DONE;
                        end
                        // Borrow ripples from seconds-ones up to minutes-tens.
                        if (sec_o_q != 4'd0) begin
                            sec_o_d = sec_o_q - 4'd1;
                        end else begin
                            sec_o_d = 4'd9;
                            if (sec_t_q != 4'd0) begin
                                sec_t_d = sec_t_q - 4'd1;
                            end else begin
                                sec_t_d = 4'd5;
                                if (min_o_q != 4'd0) begin
                                    min_o_d = min_o_q - 4'd1;
                                end else begin
                                    min_o_d = 4'd9;
                                    min_t_d = min_t_q - 4'd1;
                                end
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (run) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_tmp1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            min_t_q     <= 4'd0;
            min_o_q     <= 4'd0;
            sec_t_q     <= 4'd0;
            sec_o_q     <= 4'd0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_t_q     <= min_t_d;
            min_o_q     <= min_o_d;
            sec_t_q     <= sec_t_d;
            sec_o_q     <= sec_o_d;
            running_q   <= (state_d == RUN);
            done_q      <= (state_d == DONE);
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign min_t     = min_t_q;
    assign min_o     = min_o_q;
    assign sec_t     = sec_t_q;
    assign sec_o     = sec_o_q;
    assign state     = state_q;
    assign running   = running_q;
    assign done      = done_q;
    assign sec_pulse = sec_pulse_q;

endmodule
